// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: receiver/transmitter state encoding and parity modes        |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // xor_all is the XOR of every data bit together with the received parity bit
  function automatic logic parity_bad(input logic xor_all, input int mode);
    case (mode)
      PAR_EVEN: parity_bad = xor_all;
      PAR_ODD:  parity_bad = ~xor_all;
      default:  parity_bad = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_bit_timer: loadable bit-period down-counter, expires at zero    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 16,
  localparam int CW = $clog2(CLK_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          expire
);

  logic [CW-1:0] count;

  // Holds at zero once expired so an idle timer reads as expired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expire = (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_param: mid-bit sampling UART receiver with valid/ready output |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LOAD  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD  = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP  = IW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY != PAR_NONE);

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_t          state;
  uart_state_t          state_next;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        bit_idx_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic                 frame_err;
  logic                 frame_err_next;
  logic                 parity_err;
  logic                 parity_err_next;
  logic                 timer_load;
  logic [CW-1:0]        timer_value;
  logic                 expire;
  logic                 deliver;
  logic                 deliver_ferr;

  // Two-flop synchroniser; idle-high reset value avoids a false start
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  uart_bit_timer #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_bit_timer (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_next;
      bit_idx    <= bit_idx_next;
      shreg      <= shreg_next;
      frame_err  <= frame_err_next;
      parity_err <= parity_err_next;
    end
  end

  always_comb begin
    state_next      = state;
    bit_idx_next    = bit_idx;
    shreg_next      = shreg;
    frame_err_next  = frame_err;
    parity_err_next = parity_err;
    timer_load      = 1'b0;
    timer_value     = FULL_LOAD;
    deliver         = 1'b0;
    deliver_ferr    = frame_err;

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next      = ST_START;
          timer_load      = 1'b1;
          timer_value     = HALF_LOAD;
          frame_err_next  = 1'b0;
          parity_err_next = 1'b0;
        end
      end

      ST_START: begin
        if (expire) begin
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_DATA;
            timer_load   = 1'b1;
            bit_idx_next = '0;
          end
        end
      end

      ST_DATA: begin
        if (expire) begin
          shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
          timer_load = 1'b1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_next = '0;
            state_next   = HAS_PARITY ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
          end
        end
      end

      ST_PAR: begin
        if (expire) begin
          parity_err_next = parity_bad((^shreg) ^ rx_s, PARITY);
          timer_load      = 1'b1;
          state_next      = ST_STOP;
        end
      end

      ST_STOP: begin
        if (expire) begin
          deliver_ferr   = frame_err | ~rx_s;
          frame_err_next = deliver_ferr;
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (bit_idx == LAST_STOP) begin
            deliver      = 1'b1;
            bit_idx_next = '0;
            state_next   = deliver_ferr ? ST_BREAK : ST_IDLE;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
            timer_load   = 1'b1;
          end
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Holding register: a frame arriving while the word is unconsumed is dropped
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (deliver) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_frame_err  <= deliver_ferr;
          o_parity_err <= parity_err;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
